// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_pkg
// Brief    : Shared defaults, select-width helper and slot state encoding
//            for the registered 1xN stream demultiplexer.
// Revision : 1.0  initial release
// ============================================================================
package stream_demux_pkg;

   localparam int DW_DEFAULT = 8;

   // Select width: clog2 of the channel count, never narrower than one bit.
   function automatic int sel_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/stream_demux_1xn_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1xn_if
// Brief    : Upstream valid/ready word port plus N per-channel valid/ready
//            output ports of the 1xN stream demultiplexer.
// Revision : 1.0  initial release
// ============================================================================
interface stream_demux_1xn_if #(
   parameter int N_OUT = 2,
   parameter int DW    = stream_demux_pkg::DW_DEFAULT
) ();
   localparam int SW = stream_demux_pkg::sel_width(N_OUT);

   logic                in_valid;
   logic                in_ready;
   logic [DW-1:0]       in_data;
   logic [SW-1:0]       in_sel;
   logic [N_OUT-1:0]    out_valid;
   logic [N_OUT-1:0]    out_ready;
   logic [N_OUT*DW-1:0] out_data;
   logic                sel_err;

   // Producer/consumer side (environment)
   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, sel_err
   );

   // Demultiplexer side
   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, sel_err
   );
endinterface
`default_nettype wire

// File: rtl/stream_demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_slot
// Brief    : One-entry output buffer. Loads a word, holds it until the
//            consumer drains it, and keeps the last data after draining.
// Revision : 1.0  initial release
// ============================================================================
module stream_demux_slot
   import stream_demux_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          load_i,
   input  wire logic [DW-1:0] data_i,
   input  wire logic          ready_i,
   output logic               valid_o,
   output logic [DW-1:0]      data_o
);
   slot_state_e   state_q, state_d;
   logic [DW-1:0] data_q, data_d;
   logic          drain;

   assign valid_o = (state_q == SLOT_FULL);
   assign data_o  = data_q;
   assign drain   = valid_o && ready_i;

   // State and data registers; reset discards any buffered word at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Load wins over drain (drain+load stays FULL with new data).
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (load_i) begin
         state_d = SLOT_FULL;
         data_d  = data_i;
      end else if (drain) begin
         state_d = SLOT_EMPTY;
      end
   end
endmodule
`default_nettype wire

// File: rtl/stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1xn
// Brief    : Registered 1-to-N stream demultiplexer with a one-entry buffer
//            per channel. A full channel only stalls words addressed to it.
//            Optional macro STREAM_DEMUX_ROUND_ROBIN_EN replaces in_sel with
//            an internal round-robin destination pointer.
// Revision : 1.0  initial release
// ============================================================================
module stream_demux_1xn
   import stream_demux_pkg::*;
#(
   parameter int N_OUT = 2,
   parameter int DW    = DW_DEFAULT
) (
   input  wire logic         clk,
   input  wire logic         rst,
   stream_demux_1xn_if.slave bus
);
   localparam int SW = sel_width(N_OUT);

   logic [SW-1:0]       dest;
   logic [N_OUT-1:0]    hit;
   logic [N_OUT-1:0]    chan_open;
   logic [N_OUT-1:0]    load;
   logic [N_OUT-1:0]    slot_valid;
   logic [N_OUT*DW-1:0] slot_data;
   logic                in_range;
   logic                accept;

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
   logic [SW-1:0] ptr_q, ptr_d;

   assign dest = ptr_q;

   // Pointer steps to the next channel after every accepted word.
   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (ptr_q == SW'(N_OUT - 1)) ? '0 : ptr_q + SW'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign bus.sel_err = 1'b0;
`else
   logic sel_err_q, sel_err_d;

   assign dest = bus.in_sel;

   // Out-of-range words are consumed and dropped; flag them for one cycle.
   always_comb begin
      sel_err_d = accept && !in_range;
   end

   // Error pulse register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sel_err_q <= 1'b0;
      else     sel_err_q <= sel_err_d;
   end

   assign bus.sel_err = sel_err_q;
`endif

   // A channel can take a word if empty or being drained this cycle.
   assign chan_open    = ~slot_valid | bus.out_ready;
   assign in_range     = |hit;
   assign bus.in_ready = !in_range || (|(hit & chan_open));
   assign accept       = bus.in_valid && bus.in_ready;
   assign load         = hit & {N_OUT{accept}};

   assign bus.out_valid = slot_valid;
   assign bus.out_data  = slot_data;

   generate
      for (genvar k = 0; k < N_OUT; k++) begin : g_slot
         assign hit[k] = (dest == SW'(k));

         stream_demux_slot #(
            .DW (DW)
         ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[k]),
            .data_i  (bus.in_data),
            .ready_i (bus.out_ready[k]),
            .valid_o (slot_valid[k]),
            .data_o  (slot_data[k*DW +: DW])
         );
      end
   endgenerate
endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux_1xn
// Brief    : Directed self-checking bench for stream_demux_1xn: a 2-channel
//            instance for reset/steering/backpressure and a 3-channel
//            instance for out-of-range selects. Round-robin sequence runs when
//            STREAM_DEMUX_ROUND_ROBIN_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_stream_demux_1xn;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   stream_demux_1xn_if #(.N_OUT(2), .DW(8)) a_if ();
   stream_demux_1xn_if #(.N_OUT(3), .DW(8)) b_if ();

   stream_demux_1xn #(.N_OUT(2), .DW(8)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   stream_demux_1xn #(.N_OUT(3), .DW(8)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_sel = '0; a_if.out_ready = '0;
      b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_sel = '0; b_if.out_ready = '0;

      // Reset state
      tick();
      chk("rst_valid", a_if.out_valid, 32'h0);
      chk("rst_data",  a_if.out_data,  32'h0);
      chk("rst_err",   b_if.sel_err,   32'h0);
      rst = 1'b0;

      // Load 0xA5 into ch0 and hold it, then async reset mid-cycle
      a_if.in_valid = 1'b1; a_if.in_data = 8'hA5; a_if.in_sel = 1'b0;
      #1 chk("load_rdy", a_if.in_ready, 32'h1);
      tick();
      a_if.in_valid = 1'b0;
      chk("load_valid", a_if.out_valid, 32'h1);
      chk("load_data",  a_if.out_data[7:0], 32'hA5);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", a_if.out_valid, 32'h0);
      chk("async_data",  a_if.out_data,  32'h0);
      tick();
      rst = 1'b0;
      #1 chk("post_rst_rdy", a_if.in_ready, 32'h1);

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
      // Round robin: in_sel held at 0, words alternate ch0/ch1
      a_if.out_ready = 2'b11;
      a_if.in_valid = 1'b1; a_if.in_sel = 1'b0;
      a_if.in_data = 8'h01; tick();
      chk("rr1_valid", a_if.out_valid, 32'h1);
      chk("rr1_data",  a_if.out_data[7:0], 32'h01);
      a_if.in_data = 8'h02; tick();
      chk("rr2_valid", a_if.out_valid, 32'h2);
      chk("rr2_data",  a_if.out_data[15:8], 32'h02);
      chk("rr2_err",   a_if.sel_err, 32'h0);
      a_if.in_data = 8'h03; tick();
      chk("rr3_valid", a_if.out_valid, 32'h1);
      chk("rr3_data",  a_if.out_data[7:0], 32'h03);
      a_if.in_data = 8'h04; tick();
      chk("rr4_valid", a_if.out_valid, 32'h2);
      chk("rr4_data",  a_if.out_data[15:8], 32'h04);
      chk("rr4_err",   a_if.sel_err, 32'h0);
      a_if.in_valid = 1'b0;
      tick();
      chk("rr_drained", a_if.out_valid, 32'h0);
`else
      // Steering with both consumers ready
      a_if.out_ready = 2'b11;
      a_if.in_valid = 1'b1; a_if.in_data = 8'hA5; a_if.in_sel = 1'b0;
      tick();
      chk("st0_valid", a_if.out_valid, 32'h1);
      chk("st0_data",  a_if.out_data[7:0], 32'hA5);
      a_if.in_data = 8'h3C; a_if.in_sel = 1'b1;
      tick();
      a_if.in_valid = 1'b0;
      chk("st1_valid", a_if.out_valid, 32'h2);
      chk("st1_data",  a_if.out_data[15:8], 32'h3C);
      tick();
      chk("st_drained", a_if.out_valid, 32'h0);
      chk("st_retain",  a_if.out_data, 32'h3CA5);

      // Backpressure on ch1 while ch0 keeps flowing
      a_if.out_ready = 2'b01;
      a_if.in_valid = 1'b1; a_if.in_data = 8'h11; a_if.in_sel = 1'b1;
      tick();
      chk("bp_first", a_if.out_data[15:8], 32'h11);
      a_if.in_data = 8'h22;
      #1 chk("bp_stall_rdy", a_if.in_ready, 32'h0);
      tick();
      chk("bp_hold_valid", a_if.out_valid, 32'h2);
      chk("bp_hold_data",  a_if.out_data[15:8], 32'h11);
      a_if.in_data = 8'h55; a_if.in_sel = 1'b0;
      #1 chk("bp_ch0_rdy", a_if.in_ready, 32'h1);
      tick();
      chk("bp_ch0_valid", a_if.out_valid, 32'h3);
      chk("bp_ch0_data",  a_if.out_data[7:0], 32'h55);
      a_if.in_data = 8'h22; a_if.in_sel = 1'b1; a_if.out_ready = 2'b11;
      #1 chk("bp_release_rdy", a_if.in_ready, 32'h1);
      tick();
      a_if.in_valid = 1'b0;
      chk("bp_release_valid", a_if.out_valid, 32'h2);
      chk("bp_release_data",  a_if.out_data[15:8], 32'h22);
      tick();
      chk("bp_drained", a_if.out_valid, 32'h0);

      // Simultaneous drain and load on ch0
      a_if.out_ready = 2'b00;
      a_if.in_valid = 1'b1; a_if.in_data = 8'h11; a_if.in_sel = 1'b0;
      tick();
      chk("dl_first", a_if.out_data[7:0], 32'h11);
      a_if.out_ready = 2'b01; a_if.in_data = 8'h22;
      #1 chk("dl_rdy", a_if.in_ready, 32'h1);
      tick();
      a_if.in_valid = 1'b0;
      chk("dl_valid", a_if.out_valid, 32'h1);
      chk("dl_data",  a_if.out_data[7:0], 32'h22);
      tick();
      chk("dl_drained", a_if.out_valid, 32'h0);

      // Out-of-range select on the 3-channel instance
      b_if.in_valid = 1'b1; b_if.in_data = 8'h77; b_if.in_sel = 2'd2;
      tick();
      chk("oor_pre_valid", b_if.out_valid, 32'h4);
      b_if.in_data = 8'h99; b_if.in_sel = 2'd3;
      #1 chk("oor_rdy", b_if.in_ready, 32'h1);
      chk("oor_err_before", b_if.sel_err, 32'h0);
      tick();
      b_if.in_valid = 1'b0;
      chk("oor_err_pulse", b_if.sel_err, 32'h1);
      chk("oor_valid",     b_if.out_valid, 32'h4);
      chk("oor_data",      b_if.out_data, 32'h770000);
      tick();
      chk("oor_err_clear", b_if.sel_err, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
